ntt_poly_mult_seq: RTL and testbench
====================================

Name: ntt_poly_mult_seq

Overview:
Sequential, parametrised NTT-based cyclic polynomial multiplier: c = a·b mod (x^NPT − 1), coefficients mod Q.
- Shares one butterfly datapath and one coefficient register file between the forward NTT, pointwise multiply and inverse NTT.
- Coefficients stream in and out over valid/ready handshakes.
- Adds run-time mode select: full multiply, forward NTT only, or inverse NTT only.
- Sits beside the combinational multiplier as the area-efficient option for larger NPT.

Parameters:
Q, 17, prime modulus; NPT must divide Q−1.
NPT, 8, number of points; power of two, ≥4.
W, 5, coefficient width; must satisfy 2^W > Q.
OMEGA, 2, primitive NPT-th root of unity mod Q.
OMEGA_INV, 9, OMEGA^−1 mod Q.
NPT_INV, 15, NPT^−1 mod Q.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mode  in  2  00 multiply, 01 forward NTT of a, 10 inverse NTT of a (incl. NPT_INV scale), 11 reserved (treated as 00)
in_valid  in  1  input coefficient valid
in_ready  out  1  block accepts a coefficient
in_data  in  W  coefficient, must be < Q
out_valid  out  1  result coefficient valid
out_ready  in  1  sink accepts a coefficient
out_data  out  W  result coefficient, index 0 first
out_last  out  1  high with coefficient NPT−1
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state IDLE; in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0; all counters 0. Coefficient RAM contents are don't-care.
- Accept/emit rules: a beat is accepted when in_valid&&in_ready; a beat is emitted when out_valid&&out_ready.
- IDLE: mode is latched on the first accepted beat; state moves to LOAD_A, and that beat is stored as a[0].
- Load address mapping: coefficient i is stored at address bitrev(i), enabling an in-place DIT transform.
- LOAD_A: NPT beats total. After the last beat, mode 00 → LOAD_B; modes 01/10 → XFORM_A.
- LOAD_B: NPT beats into bank B → XFORM_A. in_ready=1 only in IDLE/LOAD_A/LOAD_B.
- XFORM_A:
  - log2(NPT) stages, NPT/2 butterflies per stage, one butterfly per cycle.
  - Butterfly: (u,v) ← (u+t mod Q, u−t mod Q), t = v·w mod Q.
  - Twiddle w comes from a table (OMEGA powers; OMEGA_INV powers when mode=10).
  - Next state: mode 00 → XFORM_B; 01 → OUT; 10 → SCALE.
- XFORM_B: same transform on bank B (forward twiddles) → PMUL.
- PMUL: NPT cycles, A[k] ← A[k]·B[k] mod Q. Then bit-reverse copy is not needed: the INTT reuses the bitrev permutation via an NPT-cycle PERM pass (A[bitrev(k)] ↔ A[k]) → XFORM_I.
- XFORM_I: inverse transform on bank A → SCALE.
- SCALE: NPT cycles, A[k] ← A[k]·NPT_INV mod Q → OUT. For mode 10, A was loaded bit-reversed, so no PERM pass is needed.
- OUT:
  - out_valid=1; out_data=A[idx], idx 0..NPT−1 in natural order (forward-only mode emits A in natural order).
  - idx advances only on an emitted beat; out_data/out_valid hold stable while out_ready=0.
  - out_last=1 at idx=NPT−1; after the last beat → IDLE.
- Latency (mode 00, NPT=8): 12-cycle XFORM per transform, 8 PMUL, 8 PERM, 8 SCALE. Total from last input beat to first out_valid is fixed = 3·(NPT/2)·log2NPT + 3·NPT + 1 cycles; the bench checks the exact value.
- Arithmetic width rules:
  - Products computed at 2W bits, reduced by % Q.
  - Sums at W+1 bits, one conditional subtract of Q.
  - Differences: add Q when negative.
  - All stored values < Q at all times.
- Inputs ≥ Q: result undefined (not checked).
- Simultaneous in_valid during compute or OUT is ignored (in_ready=0).
- Reset mid-operation aborts immediately; the next transaction starts clean.

Decomposition:
- Package ntt_seq_pkg:
  - state enum.
  - mode encodings.
  - functions: clog2, bitrev, modpow for elaboration-time twiddle tables.
  - modadd/modsub/modmul helpers.
- Sub-module ntt_butterfly_mod: combinational (u,v,w) → (u',v'), parametrised by Q and W.

Test Plan:
- Mode 00, a=[1,0,0,0,0,0,0,0], b=[1,2,3,4,5,6,7,8] → c=[1,2,3,4,5,6,7,8], out_last on 8th beat.
- Mode 00, a=x (a[1]=1), b=x^7 (b[7]=1) → c=[1,0,0,0,0,0,0,0] (cyclic wrap).
- Mode 00, a[0]=16, b[0]=16, rest 0 → c[0]=1 (256 mod 17), others 0; exact latency checked.
- Mode 01, a=[1,0,…,0] → eight 1s; mode 10, a=[1,1,…,1] → [1,0,…,0].
- Backpressure: out_ready toggled 1,0,0,1,… during OUT → data stable while stalled, no loss or duplication.
- rst_n pulsed low mid-XFORM_B → busy=0, out_valid=0 immediately; a following full multiply (first scenario) is correct.

Source files
------------

// File: rtl/ntt_seq_pkg.sv
// Shared types and elaboration-time arithmetic helpers for the sequential NTT multiplier.
package ntt_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_XFORM_A,
    ST_XFORM_B,
    ST_PMUL,
    ST_PERM,
    ST_XFORM_I,
    ST_SCALE,
    ST_OUT
  } state_e;

  typedef enum logic [1:0] {
    MODE_MUL = 2'b00,
    MODE_FWD = 2'b01,
    MODE_INV = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int bitrev(input int x, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

  function automatic int modadd(input int a, input int b, input int q);
    return (a + b) % q;
  endfunction

  function automatic int modsub(input int a, input int b, input int q);
    return (a - b + q) % q;
  endfunction

  function automatic int modmul(input int a, input int b, input int q);
    return int'((longint'(a) * longint'(b)) % longint'(q));
  endfunction

  function automatic int modpow(input int b, input int e, input int q);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = modmul(r, b, q);
    return r;
  endfunction

endpackage

// File: rtl/ntt_seq_butterfly.sv
// Combinational modular butterfly: (u, v, w) -> (u + v*w, u - v*w), all mod Q.
// With u = 0 the upper output is a plain modular product, which the top
// reuses for pointwise multiply and final scaling.
module ntt_butterfly_mod #(
  parameter int Q = 17,
  parameter int W = 5
) (
  input  logic [W-1:0] i_u,
  input  logic [W-1:0] i_v,
  input  logic [W-1:0] i_w,
  output logic [W-1:0] o_u,
  output logic [W-1:0] o_v
);

  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_t;
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;

  assign w_prod = (2*W)'(i_v) * (2*W)'(i_w);
  assign w_t    = W'(w_prod % (2*W)'(Q));
  assign w_sum  = {1'b0, i_u} + {1'b0, w_t};
  assign w_diff = {1'b0, i_u} - {1'b0, w_t};

  // One conditional subtract for the sum, add Q back when the difference wrapped.
  always_comb begin
    o_u = (w_sum >= (W+1)'(Q)) ? W'(w_sum - (W+1)'(Q)) : W'(w_sum);
    o_v = (i_u < w_t) ? W'(w_diff + (W+1)'(Q)) : W'(w_diff);
  end

endmodule

// File: rtl/ntt_poly_mult_seq.sv
// Sequential NTT cyclic polynomial multiplier, c = a*b mod (x^NPT - 1, Q).
// Coefficients are stored bit-reversed so every transform is an in-place DIT
// producing natural order; one butterfly serves all arithmetic phases.
module ntt_poly_mult_seq
  import ntt_seq_pkg::*;
#(
  parameter int Q         = 17,
  parameter int NPT       = 8,
  parameter int W         = 5,
  parameter int OMEGA     = 2,
  parameter int OMEGA_INV = 9,
  parameter int NPT_INV   = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int LOGN = clog2(NPT);
  localparam int HALF = NPT / 2;
  localparam int TWB  = LOGN - 1;

  state_e          r_state, w_state_next;
  mode_e           r_mode, w_mode_next;
  logic [LOGN-1:0] r_idx, w_idx_next;
  logic [LOGN-1:0] r_stage, w_stage_next;
  logic [W-1:0]    r_a [NPT];
  logic [W-1:0]    r_b [NPT];

  logic [LOGN-1:0] w_idx_br, w_j, w_mask, w_pos, w_top, w_bot;
  logic [TWB-1:0]  w_tw_idx;
  logic [W-1:0]    w_tw_fwd [HALF];
  logic [W-1:0]    w_tw_inv [HALF];
  logic [W-1:0]    w_op_u, w_op_v, w_op_w, w_bf_u, w_bf_v;
  logic            w_accept, w_idx_last, w_bfly_last, w_stage_last;
  logic            w_a_we0, w_a_we1, w_b_we0, w_b_we1;
  logic [LOGN-1:0] w_wa0, w_wa1;
  logic [W-1:0]    w_wd0, w_wd1;

  // Twiddle tables folded to constants at elaboration.
  for (genvar gi = 0; gi < HALF; gi++) begin : g_tw
    localparam logic [W-1:0] TW_F = W'(modpow(OMEGA, gi, Q));
    localparam logic [W-1:0] TW_I = W'(modpow(OMEGA_INV, gi, Q));
    assign w_tw_fwd[gi] = TW_F;
    assign w_tw_inv[gi] = TW_I;
  end

  for (genvar gi = 0; gi < LOGN; gi++) begin : g_br
    assign w_idx_br[gi] = r_idx[LOGN-1-gi];
  end

  // Butterfly j of stage s: pos = j mod 2^s, top = (j - pos)*2 + pos, bot = top + 2^s.
  assign w_j      = {1'b0, r_idx[LOGN-2:0]};
  assign w_mask   = (LOGN'(1) << r_stage) - LOGN'(1);
  assign w_pos    = w_j & w_mask;
  assign w_top    = ((w_j & ~w_mask) << 1) | w_pos;
  assign w_bot    = w_top | (LOGN'(1) << r_stage);
  assign w_tw_idx = TWB'(w_pos << (LOGN'(LOGN-1) - r_stage));

  assign w_accept     = in_valid && in_ready;
  assign w_idx_last   = (r_idx == LOGN'(NPT-1));
  assign w_bfly_last  = (r_idx == LOGN'(HALF-1));
  assign w_stage_last = (r_stage == LOGN'(LOGN-1));

  assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  assign out_valid = (r_state == ST_OUT);
  assign out_last  = (r_state == ST_OUT) && w_idx_last;
  assign out_data  = (r_state == ST_OUT) ? r_a[r_idx] : '0;
  assign busy      = (r_state != ST_IDLE);

  // Route the right bank and coefficient source into the shared butterfly.
  always_comb begin
    w_op_u = r_a[w_top];
    w_op_v = r_a[w_bot];
    w_op_w = ((r_state == ST_XFORM_I) || (r_mode == MODE_INV)) ? w_tw_inv[w_tw_idx]
                                                                : w_tw_fwd[w_tw_idx];
    case (r_state)
      ST_XFORM_B: begin
        w_op_u = r_b[w_top];
        w_op_v = r_b[w_bot];
        w_op_w = w_tw_fwd[w_tw_idx];
      end
      ST_PMUL: begin
        w_op_u = '0;
        w_op_v = r_a[r_idx];
        w_op_w = r_b[r_idx];
      end
      ST_SCALE: begin
        w_op_u = '0;
        w_op_v = r_a[r_idx];
        w_op_w = W'(NPT_INV);
      end
      default: ;
    endcase
  end

  ntt_butterfly_mod #(.Q(Q), .W(W)) u_bfly (
    .i_u (w_op_u),
    .i_v (w_op_v),
    .i_w (w_op_w),
    .o_u (w_bf_u),
    .o_v (w_bf_v)
  );

  // Next-state, counter and register-file write control.
  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    w_idx_next   = r_idx;
    w_stage_next = r_stage;
    w_a_we0 = 1'b0;
    w_a_we1 = 1'b0;
    w_b_we0 = 1'b0;
    w_b_we1 = 1'b0;
    w_wa0   = w_idx_br;
    w_wa1   = w_bot;
    w_wd0   = in_data;
    w_wd1   = w_bf_v;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        if (mode == MODE_FWD)      w_mode_next = MODE_FWD;
        else if (mode == MODE_INV) w_mode_next = MODE_INV;
        else                       w_mode_next = MODE_MUL;
        w_a_we0      = 1'b1;
        w_idx_next   = r_idx + LOGN'(1);
        w_state_next = ST_LOAD_A;
      end
      ST_LOAD_A, ST_LOAD_B: if (w_accept) begin
        if (r_state == ST_LOAD_A) w_a_we0 = 1'b1;
        else                      w_b_we0 = 1'b1;
        if (w_idx_last) begin
          w_idx_next = '0;
          if (r_state == ST_LOAD_A && r_mode == MODE_MUL) w_state_next = ST_LOAD_B;
          else                                            w_state_next = ST_XFORM_A;
        end else begin
          w_idx_next = r_idx + LOGN'(1);
        end
      end
      ST_XFORM_A, ST_XFORM_B, ST_XFORM_I: begin
        w_wa0 = w_top;
        w_wd0 = w_bf_u;
        if (r_state == ST_XFORM_B) begin
          w_b_we0 = 1'b1;
          w_b_we1 = 1'b1;
        end else begin
          w_a_we0 = 1'b1;
          w_a_we1 = 1'b1;
        end
        if (!w_bfly_last) begin
          w_idx_next = r_idx + LOGN'(1);
        end else begin
          w_idx_next = '0;
          if (!w_stage_last) begin
            w_stage_next = r_stage + LOGN'(1);
          end else begin
            w_stage_next = '0;
            if (r_state == ST_XFORM_B)      w_state_next = ST_PMUL;
            else if (r_state == ST_XFORM_I) w_state_next = ST_SCALE;
            else if (r_mode == MODE_MUL)    w_state_next = ST_XFORM_B;
            else if (r_mode == MODE_FWD)    w_state_next = ST_OUT;
            else                            w_state_next = ST_SCALE;
          end
        end
      end
      ST_PMUL, ST_SCALE: begin
        w_wa0      = r_idx;
        w_wd0      = w_bf_u;
        w_a_we0    = 1'b1;
        w_idx_next = r_idx + LOGN'(1);
        if (w_idx_last) w_state_next = (r_state == ST_PMUL) ? ST_PERM : ST_OUT;
      end
      ST_PERM: begin
        // Each swap pair is handled once, from its lower index.
        w_wa0      = r_idx;
        w_wd0      = r_a[w_idx_br];
        w_wa1      = w_idx_br;
        w_wd1      = r_a[r_idx];
        w_a_we0    = (r_idx < w_idx_br);
        w_a_we1    = (r_idx < w_idx_br);
        w_idx_next = r_idx + LOGN'(1);
        if (w_idx_last) w_state_next = ST_XFORM_I;
      end
      ST_OUT: if (out_ready) begin
        w_idx_next = r_idx + LOGN'(1);
        if (w_idx_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Control state register with asynchronous abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_MUL;
      r_idx   <= '0;
      r_stage <= '0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_idx   <= w_idx_next;
      r_stage <= w_stage_next;
    end
  end

  // Coefficient banks: two write ports each, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_a_we0) r_a[w_wa0] <= w_wd0;
    if (w_a_we1) r_a[w_wa1] <= w_wd1;
    if (w_b_we0) r_b[w_wa0] <= w_wd0;
    if (w_b_we1) r_b[w_wa1] <= w_wd1;
  end

endmodule

// File: tb/tb_ntt_poly_mult_seq.sv
// Directed bench for ntt_poly_mult_seq (Q=17, NPT=8, OMEGA=2).
module tb_ntt_poly_mult_seq;

  localparam int W   = 5;
  localparam int NPT = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  logic [W-1:0] va [NPT];
  logic [W-1:0] vb [NPT];
  logic [W-1:0] vc [NPT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ntt_poly_mult_seq #(
    .Q(17), .NPT(NPT), .W(W), .OMEGA(2), .OMEGA_INV(9), .NPT_INV(15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input string tag, input logic [W-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input string tag, input logic [1:0] m, input bit with_b);
    mode = m;
    for (int i = 0; i < NPT; i++) send(tag, va[i]);
    if (with_b) for (int i = 0; i < NPT; i++) send(tag, vb[i]);
  endtask

  // Cycle 0 is the cycle of the last input handshake.
  task automatic wait_out(input string tag, input bit chk_lat, input bit spam);
    int lat;
    lat = 1;
    if (spam) begin
      in_valid = 1'b1;
      in_data  = 5'd3;
    end
    while (!out_valid && lat < 500) begin
      if (spam && lat == 5) check({tag, "_in_ready_busy"}, in_ready, 0);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_out_valid"}, out_valid, 1);
    if (chk_lat) check({tag, "_latency"}, lat, 61);
  endtask

  task automatic recv(input string tag, input bit stall);
    int k, cyc;
    bit prev_stall;
    logic [W-1:0] held;
    k = 0;
    cyc = 0;
    prev_stall = 1'b0;
    held = '0;
    while (k < NPT && cyc < 200) begin
      out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (prev_stall) begin
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_data"}, out_data, held);
      end
      if (out_valid) begin
        if (out_ready) begin
          check($sformatf("%s_c%0d", tag, k), out_data, vc[k]);
          check($sformatf("%s_last%0d", tag, k), out_last, (k == NPT-1));
          k++;
          prev_stall = 1'b0;
        end else begin
          held = out_data;
          prev_stall = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check({tag, "_beats"}, k, NPT);
    check({tag, "_done_valid"}, out_valid, 0);
    check({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply by the constant 1
    va = '{1, 0, 0, 0, 0, 0, 0, 0};
    vb = '{1, 2, 3, 4, 5, 6, 7, 8};
    vc = '{1, 2, 3, 4, 5, 6, 7, 8};
    load("t1", 2'b00, 1'b1);
    wait_out("t1", 1'b1, 1'b0);
    recv("t1", 1'b0);

    // x * x^7 wraps to 1
    va = '{0, 1, 0, 0, 0, 0, 0, 0};
    vb = '{0, 0, 0, 0, 0, 0, 0, 1};
    vc = '{1, 0, 0, 0, 0, 0, 0, 0};
    load("t2", 2'b00, 1'b1);
    wait_out("t2", 1'b1, 1'b0);
    recv("t2", 1'b0);

    // 16*16 = 256 = 1 mod 17; stray input during compute must be ignored
    va = '{16, 0, 0, 0, 0, 0, 0, 0};
    vb = '{16, 0, 0, 0, 0, 0, 0, 0};
    vc = '{1, 0, 0, 0, 0, 0, 0, 0};
    load("t3", 2'b00, 1'b1);
    wait_out("t3", 1'b1, 1'b1);
    recv("t3", 1'b0);

    // Forward NTT of a delta: all ones
    va = '{1, 0, 0, 0, 0, 0, 0, 0};
    vc = '{1, 1, 1, 1, 1, 1, 1, 1};
    load("t4", 2'b01, 1'b0);
    wait_out("t4", 1'b0, 1'b0);
    recv("t4", 1'b0);

    // Inverse NTT of all ones: 8*15 = 120 = 1 mod 17 at index 0
    va = '{1, 1, 1, 1, 1, 1, 1, 1};
    vc = '{1, 0, 0, 0, 0, 0, 0, 0};
    load("t5", 2'b10, 1'b0);
    wait_out("t5", 1'b0, 1'b0);
    recv("t5", 1'b0);

    // (1 + x) * b under output backpressure: c[n] = b[n] + b[n-1]
    va = '{1, 1, 0, 0, 0, 0, 0, 0};
    vb = '{1, 2, 3, 4, 5, 6, 7, 8};
    vc = '{9, 3, 5, 7, 9, 11, 13, 15};
    load("t6", 2'b00, 1'b1);
    wait_out("t6", 1'b1, 1'b0);
    recv("t6", 1'b1);

    // Abort during the second transform, then a clean run
    va = '{1, 2, 3, 4, 5, 6, 7, 8};
    vb = '{8, 7, 6, 5, 4, 3, 2, 1};
    load("t7", 2'b00, 1'b1);
    repeat (18) @(negedge clk);
    check("t7_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_out_valid", out_valid, 0);
    check("t7_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    va = '{1, 0, 0, 0, 0, 0, 0, 0};
    vb = '{1, 2, 3, 4, 5, 6, 7, 8};
    vc = '{1, 2, 3, 4, 5, 6, 7, 8};
    load("t8", 2'b00, 1'b1);
    wait_out("t8", 1'b1, 1'b0);
    recv("t8", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
